// File: rtl/camera_capture.sv
// DVP camera capture front end: registers the pins, assembles BYTES_PER_PIXEL beats per pixel
// and tags pixels with row/col. Define CAMERA_CAPTURE_DECIMATE_EN to add i_decimate (even rows/cols only).
module camera_capture #(
   parameter int DATA_W          = 8,
   parameter int BYTES_PER_PIXEL = 2,
   parameter int ROW_W           = 10,
   parameter int COL_W           = 10,
   parameter int MAX_COLS        = 640,
   parameter int MAX_ROWS        = 480,
   parameter bit VSYNC_FRAME_LVL = 1'b1
) (
   input  logic                                i_clk,
   input  logic                                i_rst,
`ifdef CAMERA_CAPTURE_DECIMATE_EN
   input  logic                                i_decimate,
`endif
   input  logic                                i_vsync,
   input  logic                                i_href,
   input  logic [DATA_W-1:0]                   i_data,
   output logic                                o_valid,
   output logic [DATA_W*BYTES_PER_PIXEL-1:0]   o_data,
   output logic [ROW_W-1:0]                    o_row,
   output logic [COL_W-1:0]                    o_col,
   output logic                                o_frame_start,
   output logic                                o_frame_done,
   output logic [15:0]                         o_frame_cnt,
   output logic                                o_line_err
);

   localparam int PIX_W = DATA_W * BYTES_PER_PIXEL;
   localparam int IDX_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES_PER_PIXEL - 1);
   localparam logic [COL_W-1:0] COL_LIM  = COL_W'(MAX_COLS);
   localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(MAX_ROWS);

   typedef enum logic [1:0] {
      WAIT_IDLE  = 2'd0,
      WAIT_FRAME = 2'd1,
      ACTIVE     = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_vsync;
   logic                r_href;
   logic [DATA_W-1:0]   r_data;

   logic                r_in_line;
   logic [IDX_W-1:0]    r_idx;
   logic [PIX_W-1:0]    r_pix;
   logic [COL_W-1:0]    r_col;
   logic [ROW_W-1:0]    r_row;

   logic                r_valid;
   logic [PIX_W-1:0]    r_odata;
   logic [ROW_W-1:0]    r_orow;
   logic [COL_W-1:0]    r_ocol;
   logic                r_fstart;
   logic                r_fdone;
   logic [15:0]         r_fcnt;
   logic                r_lerr;

   logic                w_in_line_nxt;
   logic [IDX_W-1:0]    w_idx_nxt;
   logic [PIX_W-1:0]    w_pix_nxt;
   logic [COL_W-1:0]    w_col_nxt;
   logic [ROW_W-1:0]    w_row_nxt;
   logic                w_valid_nxt;
   logic [PIX_W-1:0]    w_odata_nxt;
   logic [ROW_W-1:0]    w_orow_nxt;
   logic [COL_W-1:0]    w_ocol_nxt;
   logic                w_fstart_nxt;
   logic                w_fdone_nxt;
   logic [15:0]         w_fcnt_nxt;
   logic                w_lerr_nxt;

   logic                w_vs_frame;
   logic                w_pix_done;
   logic [IDX_W-1:0]    w_idx_b;
   logic [COL_W-1:0]    w_col_b;
   logic                w_line_end;
   logic [PIX_W-1:0]    w_shift;
   logic                w_emit_ok;
   logic [ROW_W-1:0]    w_orow_val;
   logic [COL_W-1:0]    w_ocol_val;

   assign w_vs_frame = (r_vsync == VSYNC_FRAME_LVL);

   // First byte of a pixel ends up in the MSBs after the final shift.
   generate
      if (BYTES_PER_PIXEL == 1) begin : g_shift_one
         assign w_shift = r_data;
      end else begin : g_shift_multi
         assign w_shift = {r_pix[PIX_W-DATA_W-1:0], r_data};
      end
   endgenerate

`ifdef CAMERA_CAPTURE_DECIMATE_EN
   logic r_decim;
   logic w_decim_nxt;

   assign w_emit_ok  = !r_decim || (!r_row[0] && !r_col[0]);
   assign w_orow_val = r_decim ? (r_row >> 1) : r_row;
   assign w_ocol_val = r_decim ? (r_col >> 1) : r_col;
`else
   assign w_emit_ok  = 1'b1;
   assign w_orow_val = r_row;
   assign w_ocol_val = r_col;
`endif

   // Stage-1 pin registers; vsync resets to the frame level so a frame already
   // in progress at reset release is never mistaken for a fresh frame start.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_vsync <= VSYNC_FRAME_LVL;
         r_href  <= 1'b0;
         r_data  <= '0;
      end else begin
         r_vsync <= i_vsync;
         r_href  <= i_href;
         r_data  <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= WAIT_IDLE;
         r_in_line <= 1'b0;
         r_idx     <= '0;
         r_pix     <= '0;
         r_col     <= '0;
         r_row     <= '0;
         r_valid   <= 1'b0;
         r_odata   <= '0;
         r_orow    <= '0;
         r_ocol    <= '0;
         r_fstart  <= 1'b0;
         r_fdone   <= 1'b0;
         r_fcnt    <= '0;
         r_lerr    <= 1'b0;
`ifdef CAMERA_CAPTURE_DECIMATE_EN
         r_decim   <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_in_line <= w_in_line_nxt;
         r_idx     <= w_idx_nxt;
         r_pix     <= w_pix_nxt;
         r_col     <= w_col_nxt;
         r_row     <= w_row_nxt;
         r_valid   <= w_valid_nxt;
         r_odata   <= w_odata_nxt;
         r_orow    <= w_orow_nxt;
         r_ocol    <= w_ocol_nxt;
         r_fstart  <= w_fstart_nxt;
         r_fdone   <= w_fdone_nxt;
         r_fcnt    <= w_fcnt_nxt;
         r_lerr    <= w_lerr_nxt;
`ifdef CAMERA_CAPTURE_DECIMATE_EN
         r_decim   <= w_decim_nxt;
`endif
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_in_line_nxt = r_in_line;
      w_idx_nxt     = r_idx;
      w_pix_nxt     = r_pix;
      w_col_nxt     = r_col;
      w_row_nxt     = r_row;
      w_valid_nxt   = 1'b0;
      w_odata_nxt   = r_odata;
      w_orow_nxt    = r_orow;
      w_ocol_nxt    = r_ocol;
      w_fstart_nxt  = 1'b0;
      w_fdone_nxt   = 1'b0;
      w_fcnt_nxt    = r_fcnt;
      w_lerr_nxt    = 1'b0;
      w_pix_done    = 1'b0;
      w_idx_b       = r_idx;
      w_col_b       = r_col;
      w_line_end    = 1'b0;
`ifdef CAMERA_CAPTURE_DECIMATE_EN
      w_decim_nxt   = r_decim;
`endif

      case (r_state)
         WAIT_IDLE: begin
            if (!w_vs_frame) w_state_nxt = WAIT_FRAME;
         end

         WAIT_FRAME: begin
            if (w_vs_frame) begin
               w_state_nxt   = ACTIVE;
               w_fstart_nxt  = 1'b1;
               w_row_nxt     = '0;
               w_col_nxt     = '0;
               w_idx_nxt     = '0;
               w_in_line_nxt = 1'b0;
`ifdef CAMERA_CAPTURE_DECIMATE_EN
               w_decim_nxt   = i_decimate;
`endif
            end
         end

         ACTIVE: begin
            // A byte present in the frame-end cycle still counts, so the last
            // pixel's o_valid can coincide with o_frame_done.
            if (r_href) begin
               w_in_line_nxt = 1'b1;
               w_pix_nxt     = w_shift;
               if (r_idx == LAST_IDX) begin
                  w_idx_b    = '0;
                  w_pix_done = 1'b1;
               end else begin
                  w_idx_b    = r_idx + 1'b1;
               end
            end

            if (w_pix_done && (r_col != COL_LIM)) begin
               w_col_b = r_col + 1'b1;
               if ((r_row != ROW_LIM) && w_emit_ok) begin
                  w_valid_nxt = 1'b1;
                  w_odata_nxt = w_shift;
                  w_orow_nxt  = w_orow_val;
                  w_ocol_nxt  = w_ocol_val;
               end
            end

            w_line_end = (r_in_line && !r_href) || (!w_vs_frame && r_href);

            if (w_line_end) begin
               if ((w_idx_b != '0) || ((w_col_b != '0) && (w_col_b != COL_LIM)))
                  w_lerr_nxt = 1'b1;
               if ((w_col_b != '0) && (r_row != ROW_LIM))
                  w_row_nxt = r_row + 1'b1;
               w_col_nxt     = '0;
               w_idx_nxt     = '0;
               w_in_line_nxt = 1'b0;
            end else begin
               w_col_nxt = w_col_b;
               w_idx_nxt = w_idx_b;
            end

            if (!w_vs_frame) begin
               w_state_nxt = WAIT_FRAME;
               w_fdone_nxt = 1'b1;
               w_fcnt_nxt  = r_fcnt + 16'd1;
            end
         end

         default: w_state_nxt = WAIT_IDLE;
      endcase
   end

   assign o_valid       = r_valid;
   assign o_data        = r_odata;
   assign o_row         = r_orow;
   assign o_col         = r_ocol;
   assign o_frame_start = r_fstart;
   assign o_frame_done  = r_fdone;
   assign o_frame_cnt   = r_fcnt;
   assign o_line_err    = r_lerr;

endmodule

// File: tb/tb_camera_capture.sv
// Bench for camera_capture: three parameterisations on one clock, a line-level model with
// expected-pixel queues for the two 2-byte instances, and literal timing/value checks.
module tb_camera_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // inst 0: defaults; inst 1: MAX_COLS=2, MAX_ROWS=2; inst 2: BYTES_PER_PIXEL=1, 4x4
  logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic vs0 = 1'b0, vs1 = 1'b0, vs2 = 1'b0;
  logic hr0 = 1'b0, hr1 = 1'b0, hr2 = 1'b0;
  logic [7:0] dt0 = 8'h00, dt1 = 8'h00, dt2 = 8'h00;
  logic dec0 = 1'b0, dec1 = 1'b0, dec2 = 1'b0;

  logic v0, v1, v2, fs0, fs1, fs2, fd0, fd1, fd2, le0, le1, le2;
  logic [15:0] d0, d1;
  logic [7:0] d2;
  logic [9:0] r0, r1, r2, c0, c1, c2;
  logic [15:0] fc0, fc1, fc2;

  camera_capture u_def (
    .i_clk(clk), .i_rst(rst0),
`ifdef CAMERA_CAPTURE_DECIMATE_EN
    .i_decimate(dec0),
`endif
    .i_vsync(vs0), .i_href(hr0), .i_data(dt0),
    .o_valid(v0), .o_data(d0), .o_row(r0), .o_col(c0),
    .o_frame_start(fs0), .o_frame_done(fd0), .o_frame_cnt(fc0), .o_line_err(le0)
  );

  camera_capture #(.MAX_COLS(2), .MAX_ROWS(2)) u_small (
    .i_clk(clk), .i_rst(rst1),
`ifdef CAMERA_CAPTURE_DECIMATE_EN
    .i_decimate(dec1),
`endif
    .i_vsync(vs1), .i_href(hr1), .i_data(dt1),
    .o_valid(v1), .o_data(d1), .o_row(r1), .o_col(c1),
    .o_frame_start(fs1), .o_frame_done(fd1), .o_frame_cnt(fc1), .o_line_err(le1)
  );

  camera_capture #(.BYTES_PER_PIXEL(1), .MAX_COLS(4), .MAX_ROWS(4)) u_b1 (
    .i_clk(clk), .i_rst(rst2),
`ifdef CAMERA_CAPTURE_DECIMATE_EN
    .i_decimate(dec2),
`endif
    .i_vsync(vs2), .i_href(hr2), .i_data(dt2),
    .o_valid(v2), .o_data(d2), .o_row(r2), .o_col(c2),
    .o_frame_start(fs2), .o_frame_done(fd2), .o_frame_cnt(fc2), .o_line_err(le2)
  );

  // ---------------- model (line level) ----------------
  logic [35:0] exp_q0[$];
  logic [35:0] exp_q1[$];
  int  m_maxc[2] = '{640, 2};
  int  m_maxr[2] = '{480, 2};
  int  m_row[2]   = '{0, 0};
  bit  m_active[2] = '{0, 0};
  bit  m_armed[2]  = '{0, 0};
  int  m_err[2]    = '{0, 0};
  int  m_done[2]   = '{0, 0};
  int  m_start[2]  = '{0, 0};

  // ---------------- observation logs ----------------
  logic [35:0] log0[$];
  logic [35:0] log1[$];
  logic [35:0] log2[$];
  int vcyc0[$];
  int ecyc0[$];
  int err_cnt[3]  = '{0, 0, 0};
  int done_cnt[3] = '{0, 0, 0};
  int start_cnt[3] = '{0, 0, 0};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Compare process: every o_valid of inst 0/1 must match the head of the expected queue.
  always @(negedge clk) begin
    logic [35:0] act;
    logic [35:0] e;
    if (v0) begin
      act = {d0, r0, c0};
      log0.push_back(act);
      vcyc0.push_back(cyc);
      tests++;
      if (exp_q0.size() == 0) begin
        fails++;
        $display("FAIL pix_def: got unexpected pixel %0h, expected none", act);
      end else begin
        e = exp_q0.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL pix_def: got %0h expected %0h", act, e);
        end
      end
    end
    if (v1) begin
      act = {d1, r1, c1};
      log1.push_back(act);
      tests++;
      if (exp_q1.size() == 0) begin
        fails++;
        $display("FAIL pix_small: got unexpected pixel %0h, expected none", act);
      end else begin
        e = exp_q1.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL pix_small: got %0h expected %0h", act, e);
        end
      end
    end
    if (v2) log2.push_back({8'h00, d2, r2, c2});
    if (le0) begin err_cnt[0]++; ecyc0.push_back(cyc); end
    if (le1) err_cnt[1]++;
    if (le2) err_cnt[2]++;
    if (fd0) done_cnt[0]++;
    if (fd1) done_cnt[1]++;
    if (fd2) done_cnt[2]++;
    if (fs0) start_cnt[0]++;
    if (fs1) start_cnt[1]++;
    if (fs2) start_cnt[2]++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_vs(input int inst, input logic v);
    case (inst)
      0: vs0 = v;
      1: vs1 = v;
      default: vs2 = v;
    endcase
  endtask

  task automatic set_hd(input int inst, input logic h, input logic [7:0] d);
    case (inst)
      0: begin hr0 = h; dt0 = d; end
      1: begin hr1 = h; dt1 = d; end
      default: begin hr2 = h; dt2 = d; end
    endcase
  endtask

  task automatic set_rst(input int inst, input logic r);
    case (inst)
      0: rst0 = r;
      1: rst1 = r;
      default: rst2 = r;
    endcase
  endtask

  task automatic do_reset(input int inst, input logic v);
    set_vs(inst, v);
    set_hd(inst, 1'b0, 8'h00);
    set_rst(inst, 1'b1);
    tick(4);
    set_rst(inst, 1'b0);
    tick(2);
    if (inst == 0) exp_q0.delete();
    if (inst == 1) exp_q1.delete();
    if (inst < 2) begin
      m_active[inst] = 1'b0;
      m_row[inst]    = 0;
      m_armed[inst]  = (v == 1'b0);
    end
  endtask

  task automatic frame_on(input int inst);
    set_vs(inst, 1'b1);
    tick(3);
    if (inst < 2 && m_armed[inst] && !m_active[inst]) begin
      m_active[inst] = 1'b1;
      m_row[inst]    = 0;
      m_start[inst]++;
    end
  endtask

  task automatic frame_off(input int inst);
    set_vs(inst, 1'b0);
    tick(4);
    if (inst < 2) begin
      if (m_active[inst]) m_done[inst]++;
      m_active[inst] = 1'b0;
      m_armed[inst]  = 1'b1;
    end
  endtask

  // Expected outcome of one line of nbytes consecutive bytes base, base+1, ...
  task automatic model_line(input int inst, input int nbytes, input logic [7:0] base);
    int npix;
    int kept;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [35:0] ent;
    if (inst > 1 || !m_active[inst]) return;
    npix = nbytes / 2;
    for (int p = 0; p < npix; p++) begin
      if (p < m_maxc[inst] && m_row[inst] < m_maxr[inst]) begin
        b0 = base + 8'(2 * p);
        b1 = b0 + 8'd1;
        ent = {b0, b1, 10'(m_row[inst]), 10'(p)};
        if (inst == 0) exp_q0.push_back(ent);
        else exp_q1.push_back(ent);
      end
    end
    kept = (npix < m_maxc[inst]) ? npix : m_maxc[inst];
    if ((nbytes % 2) != 0 || (npix > 0 && kept != m_maxc[inst])) m_err[inst]++;
    if (npix > 0 && m_row[inst] < m_maxr[inst]) m_row[inst]++;
  endtask

  task automatic line(input int inst, input int nbytes, input logic [7:0] base);
    model_line(inst, nbytes, base);
    for (int k = 0; k < nbytes; k++) begin
      set_hd(inst, 1'b1, base + 8'(k));
      tick(1);
    end
    set_hd(inst, 1'b0, 8'h00);
    tick(4);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int t2, t4, tl, c0s;

    do_reset(0, 1'b0);
    do_reset(1, 1'b0);
    do_reset(2, 1'b0);
    check("rst_valid", v0, 0);
    check("rst_data", d0, 0);
    check("rst_row", r0, 0);
    check("rst_col", c0, 0);
    check("rst_strobes", {fs0, fd0, le0}, 0);
    check("rst_fcnt", fc0, 0);
    check("rst_small_outs", {v1, d1, r1, c1, fs1, fd1, fc1, le1}, 0);
    check("rst_b1_outs", {v2, d2, r2, c2, fs2, fd2, fc2, le2}, 0);

    // Test 1: two pixels at default parameters, exact latency, short-line error.
    frame_on(0);
    check("t1_fstart", start_cnt[0], 1);
    model_line(0, 4, 8'h01);
    check("t1_model_px0", exp_q0[0], {16'h0102, 10'd0, 10'd0});
    check("t1_model_px1", exp_q0[1], {16'h0304, 10'd0, 10'd1});
    check("t1_model_err", m_err[0], 1);
    set_hd(0, 1'b1, 8'h01); tick(1);
    set_hd(0, 1'b1, 8'h02); t2 = cyc; tick(1);
    set_hd(0, 1'b1, 8'h03); tick(1);
    set_hd(0, 1'b1, 8'h04); t4 = cyc; tick(1);
    set_hd(0, 1'b0, 8'h00); tl = cyc; tick(4);
    check("t1_valid_cnt", vcyc0.size(), 2);
    check("t1_lat_px0", vcyc0[0], t2 + 2);
    check("t1_lat_px1", vcyc0[1], t4 + 2);
    check("t1_err_cnt", err_cnt[0], 1);
    check("t1_err_time", ecyc0[0], tl + 2);
    check("t1_data_hold", {d0, r0, c0}, {16'h0304, 10'd0, 10'd1});
    frame_off(0);
    check("t1_fcnt", fc0, 1);

    // Test 2: row and column limits.
    frame_on(1);
    line(1, 4, 8'h10);
    line(1, 4, 8'h20);
    line(1, 4, 8'h30);
    frame_off(1);
    check("t2_pixels", log1.size(), 4);
    check("t2_px0", log1[0], {16'h1011, 10'd0, 10'd0});
    check("t2_px2", log1[2], {16'h2021, 10'd1, 10'd0});
    check("t2_px3", log1[3], {16'h2223, 10'd1, 10'd1});
    check("t2_done", done_cnt[1], 1);
    check("t2_fcnt", fc1, 1);
    check("t2_no_err", err_cnt[1], 0);

    // Test 3: partial pixel at line end, next line restarts cleanly.
    frame_on(1);
    line(1, 3, 8'h40);
    line(1, 4, 8'h50);
    check("t3_err", err_cnt[1], 1);
    check("t3_pixels", log1.size(), 7);
    check("t3_px_partial_line", log1[4], {16'h4041, 10'd0, 10'd0});
    check("t3_next_line_px0", log1[5], {16'h5051, 10'd1, 10'd0});
    check("t3_next_line_px1", log1[6], {16'h5253, 10'd1, 10'd1});
    frame_off(1);
    check("t3_fcnt", fc1, 2);

    // Test 4: reset released inside a frame, no capture until a fresh frame.
    do_reset(0, 1'b1);
    check("t4_fcnt_rst", fc0, 0);
    line(0, 4, 8'h70);
    line(0, 2, 8'h80);
    check("t4_no_pixels", log0.size(), 2);
    frame_off(0);
    check("t4_no_done", done_cnt[0], 1);
    frame_on(0);
    line(0, 4, 8'h60);
    check("t4_first_px", log0[2], {16'h6061, 10'd0, 10'd0});
    frame_off(0);
    check("t4_fcnt", fc0, 1);

    // Test 5: one byte per pixel, then reset mid-line.
    frame_on(2);
    c0s = log2.size();
    set_hd(2, 1'b1, 8'hA5); tick(1);
    set_hd(2, 1'b1, 8'h5A); tick(1);
    set_hd(2, 1'b1, 8'h77); tick(1);
    set_hd(2, 1'b1, 8'h88); set_rst(2, 1'b1); tick(1);
    check("t5_rst_outs", {v2, d2, r2, c2, fs2, fd2, fc2, le2}, 0);
    check("t5_pixels", log2.size() - c0s, 2);
    check("t5_px0", log2[c0s], {8'h00, 8'hA5, 10'd0, 10'd0});
    check("t5_px1", log2[c0s + 1], {8'h00, 8'h5A, 10'd0, 10'd1});
    set_hd(2, 1'b0, 8'h00);
    set_vs(2, 1'b0);
    tick(2);
    set_rst(2, 1'b0);
    tick(3);

`ifdef CAMERA_CAPTURE_DECIMATE_EN
    // Decimation: only even source rows/cols, reported at half coordinates.
    dec2 = 1'b1;
    frame_on(2);
    c0s = log2.size();
    line(2, 4, 8'h10);
    line(2, 4, 8'h20);
    frame_off(2);
    check("dec_pixels", log2.size() - c0s, 2);
    check("dec_px0", log2[c0s], {8'h00, 8'h10, 10'd0, 10'd0});
    check("dec_px1", log2[c0s + 1], {8'h00, 8'h12, 10'd0, 10'd1});
    check("dec_no_err", err_cnt[2], 0);
`endif

    tick(4);
    check("end_q_def_empty", exp_q0.size(), 0);
    check("end_q_small_empty", exp_q1.size(), 0);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("end_err_%0d", i), err_cnt[i], m_err[i]);
      check($sformatf("end_done_%0d", i), done_cnt[i], m_done[i]);
      check($sformatf("end_start_%0d", i), start_cnt[i], m_start[i]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
